dmem_banked: RTL and testbench
==============================

Name: dmem_banked

Overview:
- Parametrised data-memory unit for the RISC-V core's MEM stage.
- Byte-addressed, 32-bit data path, split across NBANKS single-port synchronous banks.
- Supports signed and unsigned byte/half/word loads and byte/half/word stores with byte enables.
- Registered read path with valid flag; misaligned and illegal accesses are trapped; pipeline stall freezes the unit.

Parameters:
- ADDR_W, 11, byte-address width; total capacity 2^ADDR_W bytes.
- NBANKS, 2, number of banks; power of two, 1..8. Bank select = addr[ADDR_W-1 -: log2(NBANKS)].
- ROWS (localparam), 2^(ADDR_W-2)/NBANKS, words per bank. Row index = addr[ADDR_W-1-log2(NBANKS):2].

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- stall  in  1  pipeline stall; 1 = ignore request and hold all outputs.
- req  in  1  access request valid.
- op  in  4  {is_store, funct3}. Legal codes: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, extended per op.
- rvalid  out  1  rdata valid, one cycle after an accepted load.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (nrst=0, async): rdata=0, rvalid=0, err=0, all pipeline registers cleared. Memory contents are not cleared.
- Accepted request: req=1, stall=0, op legal, address aligned.
- Alignment rules: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0. Byte ops are always aligned.
- Rejected request: req=1, stall=0, and op illegal or misaligned.
  - No bank is enabled and no write occurs.
  - Next cycle: err=1, rvalid=0, rdata holds its previous value.
- Store, accepted:
  - Only the selected bank is enabled.
  - Byte-enable mask: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << {addr[1],1'b0}; SW = 4'b1111.
  - Write data is lane-replicated (byte ×4, half ×2) and masked.
  - Write takes effect at the same rising edge. Unselected bytes are unchanged.
  - Next cycle: rvalid=0, err=0.
- Load, accepted:
  - Selected bank read at edge N. Bank select, addr[1:0] and op are registered at edge N.
  - Lane extraction and extension use these registered values, never the live inputs.
  - rdata/rvalid are registered outputs, valid after edge N+1: 2-cycle request-to-output latency, fully pipelined, one load per cycle.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Idle (req=0, stall=0): rvalid=0, err=0, rdata holds.
- Stall=1:
  - Bank enables are deasserted and no write occurs.
  - The in-flight pipeline stage and rdata/rvalid/err all hold their values.
  - A load issued before the stall delivers exactly once, with rvalid asserted only in the first unstalled cycle after it completes.
- Read-after-write: a load to the same word issued the cycle after a store returns the new data. The banks are sequential, so no forwarding is needed.
- Address wrap: none. All ADDR_W bits are decoded and every address maps to exactly one bank/row.
- Reset mid-load: the pending rvalid is discarded.
- Bank model: behavioural register array per bank with per-byte write; one access per bank per cycle.

Test Plan:
- SW 0x8765_4321 @0x004; LW @0x004 → after 2 cycles rvalid=1, rdata=0x8765_4321.
- After the above: LB @0x007 → 0xFFFF_FF87; LBU @0x007 → 0x0000_0087; LH @0x006 → 0xFFFF_8765; LHU @0x004 → 0x0000_4321.
- SB 0xAA @0x405 (bank 1 when NBANKS=2), then LW @0x404 → byte1=0xAA, other bytes unchanged. LW @0x004 still returns 0x8765_4321 (bank isolation).
- LH @0x003 and op=0011 → err pulses 1 cycle, rvalid=0, memory unchanged (verify by LW readback).
- Back-to-back LW @0x000, @0x004, @0x008 with stall=1 for 2 cycles in the middle → three rvalid pulses, in order, no duplicates, correct data.
- Assert nrst low during an in-flight load → rvalid/err/rdata=0 immediately. Rerun with NBANKS=4, ADDR_W=12 and repeat the first scenario at 0xC00.

Source files
------------

// File: rtl/dmem_banked.sv
// Banked byte-addressed data memory for the MEM stage: sized/signed loads, byte-enabled stores,
// two-stage registered read path, trap on illegal or misaligned requests, stall freezes everything.
module dmem_banked #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned NBANKS = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              stall,
  input  logic              req,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err
);

  localparam int unsigned BSEL_W    = $clog2(NBANKS);
  localparam int unsigned BSEL_BITS = (BSEL_W == 0) ? 1 : BSEL_W;
  localparam int unsigned ROW_W     = ADDR_W - 2 - BSEL_W;
  localparam int unsigned ROWS      = 2 ** ROW_W;

  typedef struct packed {
    logic [2:0]           funct3;
    logic [1:0]           boff;
    logic [BSEL_BITS-1:0] bsel;
  } ld_ctrl_t;

  logic                       op_legal;
  logic                       aligned;
  logic                       go;
  logic                       acc;
  logic                       rej;
  logic                       is_store;
  logic                       ld_acc;
  logic [BSEL_BITS-1:0]       bsel;
  logic [ROW_W-1:0]           row;
  logic [3:0]                 wbe;
  logic [31:0]                wdat;
  logic [NBANKS-1:0][31:0]    rd_all;
  logic [31:0]                rd_word;
  logic [7:0]                 lane_b;
  logic [15:0]                lane_h;
  logic [31:0]                ld_result;
  ld_ctrl_t                   ld_d;
  ld_ctrl_t                   ld_q;
  logic                       ld_v_q;

  // Request classification
  always_comb begin
    op_legal = 1'b0;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    case (op[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign go       = req & ~stall;
  assign acc      = go & op_legal & aligned;
  assign rej      = go & ~acc;
  assign is_store = op[3];
  assign ld_acc   = acc & ~is_store;
  assign row      = addr[ADDR_W-1-BSEL_W:2];

  if (BSEL_W == 0) begin : g_onebank_sel
    assign bsel = '0;
  end else begin : g_multibank_sel
    assign bsel = addr[ADDR_W-1 -: BSEL_W];
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    wbe  = 4'b1111;
    wdat = wdata;
    case (op[1:0])
      2'b00: begin
        wbe  = 4'b0001 << addr[1:0];
        wdat = {4{wdata[7:0]}};
      end
      2'b01: begin
        wbe  = addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{wdata[15:0]}};
      end
      default: begin
        wbe  = 4'b1111;
        wdat = wdata;
      end
    endcase
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [31:0] mem [ROWS];
    logic [31:0] rd_q;
    logic        en;

    assign en        = acc && (bsel == BSEL_BITS'(b));
    assign rd_all[b] = rd_q;

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
      if (en && is_store) begin
        for (int i = 0; i < 4; i++) begin
          if (wbe[i]) mem[row][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) rd_q <= '0;
      else if (en && !is_store) rd_q <= mem[row];
    end
  end

  if (NBANKS == 1) begin : g_onebank_mux
    assign rd_word = rd_all[0];
  end else begin : g_multibank_mux
    assign rd_word = rd_all[ld_q.bsel];
  end

  assign ld_d = '{funct3: op[2:0], boff: addr[1:0], bsel: bsel};

  // Lane extraction from registered control, never the live request
  always_comb begin
    lane_b = rd_word[7:0];
    case (ld_q.boff)
      2'd0:    lane_b = rd_word[7:0];
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase
    lane_h    = ld_q.boff[1] ? rd_word[31:16] : rd_word[15:0];
    ld_result = rd_word;
    case (ld_q.funct3)
      3'b000:  ld_result = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_result = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_result = {24'h0, lane_b};
      3'b101:  ld_result = {16'h0, lane_h};
      default: ld_result = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ld_v_q <= 1'b0;
      ld_q   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else if (!stall) begin
      ld_v_q <= ld_acc;
      if (ld_acc) ld_q <= ld_d;
      rvalid <= ld_v_q;
      if (ld_v_q) rdata <= ld_result;
      err    <= rej;
    end
  end

endmodule

// File: tb/tb_dmem_banked.sv
// Directed self-checking bench for dmem_banked: default geometry plus a 4-bank, 12-bit instance.
module tb_dmem_banked;

  logic        clk;
  logic        nrst;
  logic        stall;
  logic        req;
  logic [3:0]  op;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  logic        stall4;
  logic        req4;
  logic [3:0]  op4;
  logic [11:0] addr4;
  logic [31:0] wdata4;
  logic [31:0] rdata4;
  logic        rvalid4;
  logic        err4;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100,
                         LHU = 4'b0101, SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;

  dmem_banked u_dut (
    .clk(clk), .nrst(nrst), .stall(stall), .req(req), .op(op), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .err(err)
  );

  dmem_banked #(.ADDR_W(12), .NBANKS(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .stall(stall4), .req(req4), .op(op4), .addr(addr4),
    .wdata(wdata4), .rdata(rdata4), .rvalid(rvalid4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] o, input logic [10:0] a, input logic [31:0] d);
    req = r; op = o; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 11'h000, 32'h0);
  endtask

  task automatic store(input string tag, input logic [3:0] o, input logic [10:0] a, input logic [31:0] d);
    drive(1'b1, o, a, d);
    tick();
    check({tag, "_err"}, 32'(err), 32'd0);
    idle();
  endtask

  task automatic load(input string tag, input logic [3:0] o, input logic [10:0] a, input logic [31:0] exp);
    drive(1'b1, o, a, 32'h0);
    tick();
    idle();
    tick();
    check({tag, "_v"}, 32'(rvalid), 32'd1);
    check(tag, rdata, exp);
  endtask

  initial begin
    nrst = 1'b0; stall = 1'b0; idle();
    stall4 = 1'b0; req4 = 1'b0; op4 = 4'h0; addr4 = 12'h000; wdata4 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst4_rdata", rdata4, 32'h0);
    nrst = 1'b1;
    tick();

    // Basic word store/load and sized loads
    store("sw004", SW, 11'h004, 32'h8765_4321);
    load("lw004", LW, 11'h004, 32'h8765_4321);
    load("lb007", LB, 11'h007, 32'hFFFF_FF87);
    load("lbu007", LBU, 11'h007, 32'h0000_0087);
    load("lh006", LH, 11'h006, 32'hFFFF_8765);
    load("lhu004", LHU, 11'h004, 32'h0000_4321);

    // Byte/half stores into bank 1, bank isolation
    store("sw404", SW, 11'h404, 32'h1122_3344);
    store("sb405", SB, 11'h405, 32'hDEAD_BEAA);
    load("lw404a", LW, 11'h404, 32'h1122_AA44);
    store("sh406", SH, 11'h406, 32'hFFFF_5566);
    load("lw404b", LW, 11'h404, 32'h5566_AA44);
    load("lw004iso", LW, 11'h004, 32'h8765_4321);

    // Rejected requests
    drive(1'b1, LH, 11'h003, 32'h0);
    tick();
    check("mis_lh_err", 32'(err), 32'd1);
    check("mis_lh_rvalid", 32'(rvalid), 32'd0);
    check("mis_lh_rdata", rdata, 32'h8765_4321);
    idle();
    tick();
    check("err_clear", 32'(err), 32'd0);
    drive(1'b1, 4'b0011, 11'h000, 32'h0);
    tick();
    check("ill_op_err", 32'(err), 32'd1);
    drive(1'b1, SW, 11'h006, 32'hFFFF_FFFF);
    tick();
    check("mis_sw_err", 32'(err), 32'd1);
    idle();
    load("lw004_after_err", LW, 11'h004, 32'h8765_4321);

    // Stalled store must not write
    store("sw00c", SW, 11'h00C, 32'h1234_5678);
    stall = 1'b1;
    drive(1'b1, SW, 11'h00C, 32'hFFFF_FFFF);
    tick();
    check("stall_st_err", 32'(err), 32'd0);
    stall = 1'b0;
    idle();
    load("lw00c", LW, 11'h00C, 32'h1234_5678);

    // Back-to-back loads with a two-cycle stall in the middle
    store("sw000", SW, 11'h000, 32'hA0A0_A0A0);
    store("sw008", SW, 11'h008, 32'hC0C0_C0C0);
    pulses = 0;
    drive(1'b1, LW, 11'h000, 32'h0);
    tick();
    check("b2b_e1_v", 32'(rvalid), 32'd0);
    drive(1'b1, LW, 11'h004, 32'h0);
    tick();
    pulses += int'(rvalid);
    check("b2b_e2_d", rdata, 32'hA0A0_A0A0);
    stall = 1'b1;
    drive(1'b1, LW, 11'h008, 32'h0);
    tick();
    check("b2b_st1_d", rdata, 32'hA0A0_A0A0);
    tick();
    check("b2b_st2_d", rdata, 32'hA0A0_A0A0);
    stall = 1'b0;
    tick();
    pulses += int'(rvalid);
    check("b2b_e5_d", rdata, 32'h8765_4321);
    idle();
    tick();
    pulses += int'(rvalid);
    check("b2b_e6_d", rdata, 32'hC0C0_C0C0);
    tick();
    pulses += int'(rvalid);
    check("b2b_pulses", 32'(pulses), 32'd3);

    // Reset while a load is in flight
    drive(1'b1, LW, 11'h000, 32'h0);
    tick();
    drive(1'b1, LW, 11'h004, 32'h0);
    tick();
    check("pre_rst_v", 32'(rvalid), 32'd1);
    idle();
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    tick();
    nrst = 1'b1;
    tick();
    check("post_rst_rvalid", 32'(rvalid), 32'd0);

    // Four-bank, 12-bit instance at the top bank
    req4 = 1'b1; op4 = SW; addr4 = 12'hC00; wdata4 = 32'h8765_4321;
    tick();
    check("b4_sw_err", 32'(err4), 32'd0);
    op4 = LW; wdata4 = 32'h0;
    tick();
    req4 = 1'b0;
    tick();
    check("b4_lw_v", 32'(rvalid4), 32'd1);
    check("b4_lw_d", rdata4, 32'h8765_4321);
    req4 = 1'b1; op4 = LHU; addr4 = 12'hC02;
    tick();
    op4 = LB; addr4 = 12'hC03;
    tick();
    check("b4_lhu_d", rdata4, 32'h0000_8765);
    req4 = 1'b0;
    tick();
    check("b4_lb_d", rdata4, 32'hFFFF_FF87);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
